// File: rtl/bcd_pkg.sv
// Shared types, state encoding and sizing helper for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Number of decimal digits needed to represent 2^width - 1.
    function automatic int min_bcd_digits(input int width);
        longint unsigned v;
        int              n;
        v = (64'd1 << width) - 64'd1;
        n = 1;
        for (int i = 0; i < 20; i++) begin
            if (v >= 64'd10) begin
                v = v / 64'd10;
                n = n + 1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets +3 before the shift.
module bcd_add3_digit
    import bcd_pkg::*;
(
    input  bcd_digit_t i_digit,
    output bcd_digit_t o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/binary_2_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with start/busy/done handshake
// and a sticky overflow flag for values that do not fit in DIGITS digits.
module binary_2_bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [WIDTH-1:0]    bn,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd,
    output logic                overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int SCR_W = 4 * DIGITS;
    // When enough digits exist the top digit can never carry out, so the flag folds away.
    localparam bit OVF_POSSIBLE = (DIGITS < min_bcd_digits(WIDTH));

    state_t             r_state;
    logic [WIDTH-1:0]   r_shift;
    logic [SCR_W-1:0]   r_scratch;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf_acc;

    logic [SCR_W-1:0]   w_adj;
    logic [SCR_W-1:0]   w_scratch_next;
    logic               w_carry;
    logic               w_last;

    genvar k;
    generate
        for (k = 0; k < DIGITS; k++) begin : g_digit
            bcd_add3_digit u_add3 (
                .i_digit (r_scratch[4*k +: 4]),
                .o_digit (w_adj[4*k +: 4])
            );
        end
    endgenerate

    assign w_scratch_next = {w_adj[SCR_W-2:0], r_shift[WIDTH-1]};
    assign w_carry        = OVF_POSSIBLE ? w_adj[SCR_W-1] : 1'b0;
    assign w_last         = (r_cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_ovf_acc <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bcd       <= '0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_shift   <= bn;
                        r_scratch <= '0;
                        r_ovf_acc <= 1'b0;
                        r_cnt     <= CNT_W'(WIDTH);
                        busy      <= 1'b1;
                        r_state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_scratch <= w_scratch_next;
                    r_shift   <= r_shift << 1;
                    r_ovf_acc <= r_ovf_acc | w_carry;
                    r_cnt     <= r_cnt - CNT_W'(1);
                    if (w_last) begin
                        bcd      <= w_scratch_next;
                        overflow <= r_ovf_acc | w_carry;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_binary_2_bcd_seq.sv
// Directed bench for binary_2_bcd_seq: three instances (8/3, 8/2, 4/2) sharing clock and reset.
module tb_binary_2_bcd_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       a_start, a_busy, a_done, a_ovf;
    logic [7:0] a_bn;
    logic [11:0] a_bcd;
    logic       b_start, b_busy, b_done, b_ovf;
    logic [7:0] b_bn;
    logic [7:0] b_bcd;
    logic       c_start, c_busy, c_done, c_ovf;
    logic [3:0] c_bn;
    logic [7:0] c_bcd;

    int checks = 0;
    int errors = 0;

    binary_2_bcd_seq #(.WIDTH(8), .DIGITS(3)) u_a (
        .clk(clk), .reset(rst_n), .start(a_start), .bn(a_bn),
        .busy(a_busy), .done(a_done), .bcd(a_bcd), .overflow(a_ovf));
    binary_2_bcd_seq #(.WIDTH(8), .DIGITS(2)) u_b (
        .clk(clk), .reset(rst_n), .start(b_start), .bn(b_bn),
        .busy(b_busy), .done(b_done), .bcd(b_bcd), .overflow(b_ovf));
    binary_2_bcd_seq #(.WIDTH(4), .DIGITS(2)) u_c (
        .clk(clk), .reset(rst_n), .start(c_start), .bn(c_bn),
        .busy(c_busy), .done(c_done), .bcd(c_bcd), .overflow(c_ovf));

    function automatic logic [11:0] ref_bcd(input int v, input int digits);
        logic [11:0] r;
        int x;
        r = '0;
        x = v;
        for (int d = 0; d < digits; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input int v, input int digits);
        int p;
        p = 1;
        for (int d = 0; d < digits; d++) p = p * 10;
        return (v >= p);
    endfunction

    function automatic logic get_done(input int sel);
        case (sel)
            0: return a_done;
            1: return b_done;
            default: return c_done;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            0: return a_busy;
            1: return b_busy;
            default: return c_busy;
        endcase
    endfunction

    function automatic logic get_ovf(input int sel);
        case (sel)
            0: return a_ovf;
            1: return b_ovf;
            default: return c_ovf;
        endcase
    endfunction

    function automatic logic [11:0] get_bcd(input int sel);
        case (sel)
            0: return a_bcd;
            1: return {4'b0, b_bcd};
            default: return {4'b0, c_bcd};
        endcase
    endfunction

    task automatic drive(input int sel, input logic s, input int v);
        case (sel)
            0: begin a_start = s; a_bn = 8'(v); end
            1: begin b_start = s; b_bn = 8'(v); end
            default: begin c_start = s; c_bn = 4'(v); end
        endcase
    endtask

    // One conversion: lat is the edge count from the accepting edge to done (-1 on timeout).
    task automatic conv(input int sel, input int v, output logic [11:0] r, output logic ovf,
                        output int lat, output int bcnt);
        @(negedge clk);
        drive(sel, 1'b1, v);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, v);
        bcnt = get_busy(sel) ? 1 : 0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (get_done(sel)) begin
                lat = i;
                break;
            end
            if (get_busy(sel)) bcnt++;
        end
        r = get_bcd(sel);
        ovf = get_ovf(sel);
    endtask

    task automatic test_reset();
        @(posedge clk);
        @(negedge clk);
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", a_busy); end
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", a_done); end
        checks++; if (a_bcd !== 12'h000) begin errors++; $display("FAIL reset_bcd got %h want 000", a_bcd); end
        checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", a_ovf); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [11:0] r; logic o; int lat, bc;
        conv(0, 255, r, o, lat, bc);
        checks++; if (r !== 12'h255) begin errors++; $display("FAIL bcd_255 got %h want 255", r); end
        checks++; if (o !== 1'b0) begin errors++; $display("FAIL ovf_255 got %b want 0", o); end
        checks++; if (lat != 8) begin errors++; $display("FAIL latency_255 got %0d want 8", lat); end
        checks++; if (bc != 8) begin errors++; $display("FAIL busy_cycles got %0d want 8", bc); end
        conv(0, 0, r, o, lat, bc);
        checks++; if (r !== 12'h000 || o !== 1'b0) begin errors++; $display("FAIL bcd_0 got %h/%b want 000/0", r, o); end
        conv(0, 99, r, o, lat, bc);
        checks++; if (r !== 12'h099 || o !== 1'b0) begin errors++; $display("FAIL bcd_99 got %h/%b want 099/0", r, o); end
    endtask

    task automatic test_sweep();
        logic [11:0] r, e; logic o; int lat, bc; bit dig_ok;
        for (int v = 0; v < 256; v++) begin
            conv(0, v, r, o, lat, bc);
            e = ref_bcd(v, 3);
            dig_ok = 1'b1;
            for (int d = 0; d < 3; d++) if (r[4*d +: 4] > 4'd9) dig_ok = 1'b0;
            checks++;
            if (!dig_ok) begin errors++; $display("FAIL sweep_digit v=%0d got %h", v, r); end
            checks++;
            if (r !== e || o !== 1'b0 || lat != 8)
                begin errors++; $display("FAIL sweep v=%0d got %h/%b lat %0d want %h/0 lat 8", v, r, o, lat, e); end
        end
    endtask

    task automatic test_overflow();
        logic [11:0] r; logic o; int lat, bc;
        conv(1, 255, r, o, lat, bc);
        checks++; if (r[7:0] !== 8'h55) begin errors++; $display("FAIL ovf_bcd got %h want 55", r[7:0]); end
        checks++; if (o !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", o); end
        conv(1, 42, r, o, lat, bc);
        checks++; if (r[7:0] !== 8'h42) begin errors++; $display("FAIL ovf_clr_bcd got %h want 42", r[7:0]); end
        checks++; if (o !== 1'b0) begin errors++; $display("FAIL ovf_clr_flag got %b want 0", o); end
    endtask

    task automatic test_back_to_back();
        int ndone; int j1, j2; logic [11:0] r1, r2;
        ndone = 0; j1 = -1; j2 = -1; r1 = '0; r2 = '0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            drive(0, 1'b1, j * 13 + 5);
            @(posedge clk);
            #1;
            if (a_done) begin
                ndone++;
                if (ndone == 1) begin j1 = j; r1 = a_bcd; end
                if (ndone == 2) begin j2 = j; r2 = a_bcd; end
            end
        end
        @(negedge clk);
        drive(0, 1'b0, 0);
        repeat (12) @(posedge clk);
        checks++; if (ndone != 2) begin errors++; $display("FAIL b2b_count got %0d want 2", ndone); end
        checks++; if (j1 != 8 || r1 !== ref_bcd(5, 3))
            begin errors++; $display("FAIL b2b_first got edge %0d %h want edge 8 %h", j1, r1, ref_bcd(5, 3)); end
        checks++; if (j2 != 17 || r2 !== ref_bcd(122, 3))
            begin errors++; $display("FAIL b2b_second got edge %0d %h want edge 17 %h", j2, r2, ref_bcd(122, 3)); end
        #1;
        checks++; if (a_bcd !== ref_bcd(239, 3))
            begin errors++; $display("FAIL b2b_third got %h want %h", a_bcd, ref_bcd(239, 3)); end
    endtask

    task automatic test_reset_mid();
        logic [11:0] r; logic o; int lat, bc, nd;
        @(negedge clk);
        drive(0, 1'b1, 200);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (a_busy !== 1'b0 || a_done !== 1'b0 || a_bcd !== 12'h000 || a_ovf !== 1'b0)
            begin errors++; $display("FAIL async_reset got busy %b done %b bcd %h ovf %b want 0/0/000/0",
                                     a_busy, a_done, a_bcd, a_ovf); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (a_done) nd++;
        end
        checks++; if (nd != 0) begin errors++; $display("FAIL no_done_after_reset got %0d want 0", nd); end
        conv(0, 200, r, o, lat, bc);
        checks++; if (r !== 12'h200 || o !== 1'b0 || lat != 8)
            begin errors++; $display("FAIL post_reset got %h/%b lat %0d want 200/0 lat 8", r, o, lat); end
    endtask

    task automatic test_width4();
        logic [11:0] r; logic o; int lat, bc;
        for (int v = 0; v < 16; v++) begin
            conv(2, v, r, o, lat, bc);
            checks++;
            if (r[7:0] !== ref_bcd(v, 2) || o !== ref_ovf(v, 2) || lat != 4)
                begin errors++; $display("FAIL w4 v=%0d got %h/%b lat %0d want %h/0 lat 4",
                                         v, r[7:0], o, lat, ref_bcd(v, 2)); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_start = 1'b0; a_bn = '0;
        b_start = 1'b0; b_bn = '0;
        c_start = 1'b0; c_bn = '0;
        test_reset();
        test_basic();
        test_sweep();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_width4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/binary_2_bcd_seq.md
Name: binary_2_bcd_seq

Overview:
Parametrised, sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. It replaces the fixed 4-bit combinational converter with a WIDTH-bit input, a DIGITS-digit output, a start/busy/done handshake and an overflow flag. It sits between binary datapath results and seven-segment or display drivers, one conversion at a time.

Parameters:
WIDTH, 8, bit width of the binary input (legal range 1 to 32)
DIGITS, 3, number of BCD digits produced (legal range 1 to 10); 4*DIGITS output bits

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately
start  input  1  request a conversion; sampled only in IDLE
bn  input  WIDTH  binary operand, captured on the accepting edge
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse: bcd and overflow are updated
bcd  output  4*DIGITS  result; digit k occupies bits [4k+3:4k] (k=0 is units); held between conversions
overflow  output  1  value did not fit in DIGITS digits; valid with done, held until the next done

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy=0, done=0, bcd=0, overflow=0; internal shift register, scratch digits and counter cleared. A conversion in flight is abandoned and no done is issued.
- FSM has two states, IDLE and SHIFT.
- IDLE: on an edge with start=1, load bn into the shift register, clear the scratch digits and overflow accumulator, load the counter with WIDTH, go to SHIFT, busy=1. With start=0, stay in IDLE.
- SHIFT: each edge performs one iteration:
  - every scratch digit >= 5 gets +3 (per-digit, combinational);
  - then the {scratch digits, shift register} are shifted left by 1, bringing in the bn MSB;
  - any bit shifted out of the top digit sets the overflow accumulator (sticky);
  - the counter decrements.
- On the edge that performs iteration WIDTH:
  - bcd is loaded with the final digits;
  - overflow is loaded with the accumulator;
  - done=1 for exactly the following cycle;
  - busy=0; state returns to IDLE.
- Latency: start sampled at edge T; iterations run on edges T+1 to T+WIDTH; done is high in the cycle after edge T+WIDTH. busy is high from edge T until edge T+WIDTH.
- start while busy=1 is ignored, and bn changes during SHIFT have no effect.
- start=1 during the done cycle is accepted (FSM already in IDLE), so conversions can run back-to-back with one idle-accept edge between them.
- Overflow: bcd holds the value mod 10^DIGITS. When DIGITS >= ceil(WIDTH*log10(2)), overflow can never assert.
- Width rules: scratch register is 4*DIGITS bits and the counter is clog2(WIDTH+1) bits. No arithmetic beyond the 4-bit add-3.

Decomposition:
- Shared package bcd_pkg holds:
  - typedef bcd_digit_t (4-bit);
  - function min_bcd_digits(width), returning the digits needed for 2^width-1;
  - state encoding constants ST_IDLE and ST_SHIFT.
- One natural sub-module, bcd_add3_digit: combinational, 4-bit in and 4-bit out, adds 3 when the input is >= 5. It is instantiated DIGITS times through a generate loop.

Test Plan:
- WIDTH=8, DIGITS=3: bn=255, start pulse -> done after 8 iterations (9th cycle after the start edge), bcd=12'h255, overflow=0; busy high for exactly 8 cycles.
- WIDTH=8, DIGITS=3: bn=0 and bn=99 -> bcd=12'h000 and 12'h099, overflow=0. Sweep all 256 inputs against a reference model: every bcd digit <= 9, with exact value match.
- WIDTH=8, DIGITS=2: bn=255 -> bcd=8'h55, overflow=1. A following bn=42 -> bcd=8'h42, overflow=0 (flag cleared by the new done).
- Handshake: start held high throughout with bn changing every cycle -> only the bn values sampled in IDLE are converted; start asserted in the done cycle starts the next conversion immediately.
- Reset mid-operation: bn=200, start, then reset=0 asynchronously after 3 cycles -> busy, done, bcd and overflow go to 0 without waiting for a clock; no done pulse afterwards. A new start after release converts correctly.
- WIDTH=4, DIGITS=2: bn = 0 to 15 -> bcd = 8'h00 to 8'h15, matching the legacy 4-bit converter for 0 to 9.
